seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//   Inverse of the digit->7-segment encoder: samples a multiplexed 7-segment scan bus
//   (segment pattern plus one-hot digit select) and recovers per-digit BCD codes.
//   A pattern commits only after it has been stable for several samples; when every
//   digit has committed, the whole frame is published on a valid/ready handshake.
//   Sits on the display-readback / self-check path next to the display driver.
// PARAMETERS
//   N_DIGITS   4  number of scanned digits (width of digit_sel)
//   STABLE_CNT 3  consecutive identical samples required before a digit commits (>=2)
// PORTS
//   clk          in   1           single system clock, rising edge
//   rst_n        in   1           synchronous reset, active-low
//   seg          in   7           segment pattern {a,b,c,d,e,f,g}; bit6=a, bit0=g; 1=lit
//   digit_sel    in   N_DIGITS    one-hot digit enable; bit i selects digit i
//   frame_ready  in   1           consumer accepts the frame when frame_valid=1
//   frame_valid  out  1           digits/blank/bad hold a complete frame
//   digits       out  4*N_DIGITS  decoded code per digit; digit i at [4i+3:4i]
//   blank        out  N_DIGITS    digit i was dark (all segments 0)
//   bad          out  N_DIGITS    digit i carried an unrecognised pattern
//   overrun      out  1           sticky: unaccepted frame was overwritten
// BEHAVIOUR
// - Decode table (seg -> code):
//   1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5,
//   1011111->6, 1110010->7, 1111111->8, 1111011->9, 0000001->F (dash).
//   0000000 -> code A with blank=1. Any other pattern -> code E with bad=1.
// - Reset (rst_n=0 at an edge): all outputs 0, and every internal register cleared:
//   sample register, counter, committed flag, shadow frame, seen mask.
// - Sampling, every edge: {digit_sel,seg} is registered. If the new value equals the
//   registered value and digit_sel is one-hot, cnt <= min(cnt+1, STABLE_CNT).
//   Otherwise cnt <= 1 and committed <= 0.
// - digit_sel zero or multi-hot: the sample is never committed; it breaks stability.
// - Commit: on the edge after cnt==STABLE_CNT with committed=0, the decoded
//   code/blank/bad is written to shadow[idx], seen[idx] <= 1, and committed <= 1.
//   This gives exactly one commit per stable run.
// - Latency: a pattern held from edge E commits at edge E+STABLE_CNT.
// - Frame completion: on the edge after seen becomes all ones, shadow is copied to
//   the outputs, frame_valid <= 1, and seen <= 0. The completing digit is included.
//   For the last digit, frame_valid therefore rises at edge E+STABLE_CNT+1.
// - A digit re-committing before the frame completes overwrites its shadow entry.
// - Handshake: a frame is accepted on an edge with frame_valid & frame_ready.
//   Outputs hold stable while frame_valid=1 and frame_ready=0.
//   On accept with no new frame: frame_valid <= 0 and overrun <= 0.
//   New frame while valid & !ready: outputs are overwritten, frame_valid stays 1,
//   overrun <= 1.
//   New frame in the same edge as accept: the new frame loads, frame_valid stays 1,
//   overrun is unchanged.
// - Reset mid-operation: partial frame discarded; the next frame needs all N_DIGITS.
// CONFIGURATION
// - SEG_ACTIVE_LOW_EN defined: seg and digit_sel are inverted at the input register
//   (common-anode panels, 0=lit/selected). All behaviour above applies post-inversion.
// - SEG_ACTIVE_LOW_EN undefined: inputs are used as-is (1=lit/selected).
// TESTING (N_DIGITS=4, STABLE_CNT=3, macro undefined unless stated)
// 1. Scan digits 0..3 with 1111110,0110000,1101101,1111001, 4 cycles each,
//    frame_ready=1 -> one frame_valid pulse, digits=16'h3210, blank=0, bad=0.
// 2. Digit 2 held only 2 cycles, then the scan continues -> no frame.
//    On the next full scan, frame_valid=1 and digit 2 holds the new value.
// 3. digit2=0000000, digit3=0000001, digit0=1010101 -> digits[11:8]=A, blank[2]=1;
//    digits[15:12]=F; digits[3:0]=E, bad[0]=1.
// 4. Two full frames with frame_ready=0 -> the second frame is visible, overrun=1.
//    Then frame_ready=1 for one cycle -> frame_valid=0, overrun=0.
// 5. rst_n=0 for 1 cycle after digits 0..2 commit -> all outputs 0.
//    Completing only digit 3 produces no frame.
// 6. SEG_ACTIVE_LOW_EN, seg=~7'b1111011, digit_sel=~4'b0001, held 3 cycles on all
//    digits (inverted) -> digits=16'h9999.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers per-digit BCD codes from a multiplexed 7-segment scan bus.
// Optional build macro SEG_ACTIVE_LOW_EN inverts seg/digit_sel for common-anode panels.
`default_nettype none

module seg_scan_decoder #(
   parameter int N_DIGITS   = 4,
   parameter int STABLE_CNT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg,
   input  logic [N_DIGITS-1:0]   digit_sel,
   input  logic                  frame_ready,
   output logic                  frame_valid,
   output logic [4*N_DIGITS-1:0] digits,
   output logic [N_DIGITS-1:0]   blank,
   output logic [N_DIGITS-1:0]   bad,
   output logic                  overrun
);

   localparam int            CW      = $clog2(STABLE_CNT + 1);
   localparam int            SW      = N_DIGITS + 7;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // Returns {bad, blank, code}
   function automatic logic [5:0] decode(input logic [6:0] p);
      case (p)
         7'b1111110: decode = 6'h00;
         7'b0110000: decode = 6'h01;
         7'b1101101: decode = 6'h02;
         7'b1111001: decode = 6'h03;
         7'b0110011: decode = 6'h04;
         7'b1011011: decode = 6'h05;
         7'b1011111: decode = 6'h06;
         7'b1110010: decode = 6'h07;
         7'b1111111: decode = 6'h08;
         7'b1111011: decode = 6'h09;
         7'b0000001: decode = 6'h0F;
         7'b0000000: decode = 6'h1A;
         default:    decode = 6'h2E;
      endcase
   endfunction

   logic [SW-1:0]         in_s;
`ifdef SEG_ACTIVE_LOW_EN
   assign in_s = ~{digit_sel, seg};
`else
   assign in_s = {digit_sel, seg};
`endif

   logic [SW-1:0]         samp_q, samp_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  committed_q, committed_d;
   logic [4*N_DIGITS-1:0] sh_code_q, sh_code_d;
   logic [N_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic [N_DIGITS-1:0]   sh_bad_q, sh_bad_d;
   logic [N_DIGITS-1:0]   seen_q, seen_d;
   logic                  frame_valid_q, frame_valid_d;
   logic [4*N_DIGITS-1:0] digits_q, digits_d;
   logic [N_DIGITS-1:0]   blank_q, blank_d;
   logic [N_DIGITS-1:0]   bad_q, bad_d;
   logic                  overrun_q, overrun_d;

   logic [N_DIGITS-1:0]   samp_sel;
   logic [5:0]            dec;
   logic                  commit;
   logic                  seen_full;
   logic                  stable;

   assign samp_sel  = samp_q[SW-1:7];
   assign dec       = decode(samp_q[6:0]);
   // cnt_q can only reach CNT_MAX on a one-hot sample, so samp_sel is one-hot here
   assign commit    = (cnt_q == CNT_MAX) && !committed_q;
   assign seen_full = &seen_q;
   assign stable    = (in_s == samp_q) && $onehot(in_s[SW-1:7]);

   always_comb begin
      samp_d        = in_s;
      cnt_d         = cnt_q;
      committed_d   = committed_q;
      sh_code_d     = sh_code_q;
      sh_blank_d    = sh_blank_q;
      sh_bad_d      = sh_bad_q;
      seen_d        = seen_full ? '0 : seen_q;
      frame_valid_d = frame_valid_q;
      digits_d      = digits_q;
      blank_d       = blank_q;
      bad_d         = bad_q;
      overrun_d     = overrun_q;

      if (commit) begin
         committed_d = 1'b1;
         seen_d      = seen_d | samp_sel;
         for (int i = 0; i < N_DIGITS; i++) begin
            if (samp_sel[i]) begin
               sh_code_d[4*i +: 4] = dec[3:0];
               sh_blank_d[i]       = dec[4];
               sh_bad_d[i]         = dec[5];
            end
         end
      end

      if (stable) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
         cnt_d       = CNT_ONE;
         committed_d = 1'b0;
      end

      if (seen_full) begin
         digits_d      = sh_code_q;
         blank_d       = sh_blank_q;
         bad_d         = sh_bad_q;
         frame_valid_d = 1'b1;
         if (frame_valid_q && !frame_ready) begin
            overrun_d = 1'b1;
         end
      end else if (frame_valid_q && frame_ready) begin
         frame_valid_d = 1'b0;
         overrun_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         samp_q        <= '0;
         cnt_q         <= '0;
         committed_q   <= 1'b0;
         sh_code_q     <= '0;
         sh_blank_q    <= '0;
         sh_bad_q      <= '0;
         seen_q        <= '0;
         frame_valid_q <= 1'b0;
         digits_q      <= '0;
         blank_q       <= '0;
         bad_q         <= '0;
         overrun_q     <= 1'b0;
      end else begin
         samp_q        <= samp_d;
         cnt_q         <= cnt_d;
         committed_q   <= committed_d;
         sh_code_q     <= sh_code_d;
         sh_blank_q    <= sh_blank_d;
         sh_bad_q      <= sh_bad_d;
         seen_q        <= seen_d;
         frame_valid_q <= frame_valid_d;
         digits_q      <= digits_d;
         blank_q       <= blank_d;
         bad_q         <= bad_d;
         overrun_q     <= overrun_d;
      end
   end

   assign frame_valid = frame_valid_q;
   assign digits      = digits_q;
   assign blank       = blank_q;
   assign bad         = bad_q;
   assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: decode table vectors, directed multi-cycle sequences,
// and randomized scans checked against a history-based reference model.
`default_nettype none

module tb_seg_scan_decoder;

   localparam int N = 4;
   localparam int S = 3;
   localparam logic [6:0] GLYPH [11] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
      7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011, 7'b0000001};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  digit_sel;
   logic        frame_ready;
   logic        frame_valid;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic [3:0]  bad;
   logic        overrun;

   always #5 clk = ~clk;

   seg_scan_decoder #(.N_DIGITS(N), .STABLE_CNT(S)) dut (
      .clk(clk), .rst_n(rst_n), .seg(seg), .digit_sel(digit_sel),
      .frame_ready(frame_ready), .frame_valid(frame_valid), .digits(digits),
      .blank(blank), .bad(bad), .overrun(overrun));

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [10:0] hist[$];
   logic [3:0]  m_code[4];
   logic        m_sblank[4];
   logic        m_sbad[4];
   logic [3:0]  m_seen;
   logic        m_valid, m_overrun;
   logic [15:0] m_digits;
   logic [3:0]  m_blank, m_bad;

   function automatic void ref_decode(input logic [6:0] p, output logic [3:0] c,
                                      output logic bl, output logic bd);
      c = 4'hE; bl = 1'b0; bd = 1'b1;
      if (p == 7'b0) begin
         c = 4'hA; bl = 1'b1; bd = 1'b0;
      end
      for (int k = 0; k < 11; k++) begin
         if (p == GLYPH[k]) begin
            c  = (k == 10) ? 4'hF : 4'(k);
            bd = 1'b0;
         end
      end
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < N; k++) begin
         m_code[k] = 4'h0; m_sblank[k] = 1'b0; m_sbad[k] = 1'b0;
      end
      m_seen = 4'h0; m_valid = 1'b0; m_overrun = 1'b0;
      m_digits = 16'h0; m_blank = 4'h0; m_bad = 4'h0;
   endtask

   task automatic model_edge(input logic [10:0] x, input logic rdy, input logic rn);
      logic [10:0] last;
      int          run;
      logic        full;
      if (!rn) begin
         model_reset();
         return;
      end
      full = (m_seen == 4'hF);
      // Frame publication uses the shadow as it stood before this edge
      if (full) begin
         for (int k = 0; k < N; k++) begin
            m_digits[4*k +: 4] = m_code[k];
            m_blank[k] = m_sblank[k];
            m_bad[k]   = m_sbad[k];
         end
         if (m_valid && !rdy) m_overrun = 1'b1;
         m_valid = 1'b1;
         m_seen  = 4'h0;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
         m_overrun = 1'b0;
      end
      // A digit commits when its trailing run of identical one-hot samples is exactly S long
      run = 0;
      if (hist.size() > 0) begin
         last = hist[hist.size()-1];
         if ($countones(last[10:7]) == 1) begin
            for (int i = hist.size() - 1; i >= 0; i--) begin
               if (hist[i] == last) run++;
               else break;
            end
         end
      end
      if (run == S) begin
         for (int k = 0; k < N; k++) begin
            if (last[7+k]) begin
               ref_decode(last[6:0], m_code[k], m_sblank[k], m_sbad[k]);
               m_seen[k] = 1'b1;
            end
         end
      end
      hist.push_back(x);
      while (hist.size() > S + 1) void'(hist.pop_front());
   endtask

   task automatic step(input logic [6:0] s, input logic [3:0] d, input logic r, input logic rn);
`ifdef SEG_ACTIVE_LOW_EN
      seg = ~s; digit_sel = ~d;
`else
      seg = s; digit_sel = d;
`endif
      frame_ready = r;
      rst_n = rn;
      @(posedge clk);
      model_edge({d, s}, r, rn);
      #1;
      checks++;
      if ({frame_valid, digits, blank, bad, overrun} !==
          {m_valid, m_digits, m_blank, m_bad, m_overrun}) begin
         errors++;
         $display("FAIL model_cycle t=%0t got v=%b d=%h bl=%b bd=%b ov=%b want v=%b d=%h bl=%b bd=%b ov=%b",
                  $time, frame_valid, digits, blank, bad, overrun,
                  m_valid, m_digits, m_blank, m_bad, m_overrun);
      end
   endtask

   task automatic idle(input logic r);
      step(7'b0, 4'b0, r, 1'b1);
   endtask

   task automatic scan_digit(input logic [6:0] p, input int d, input int hold, input logic r);
      for (int h = 0; h < hold; h++) step(p, 4'(1 << d), r, 1'b1);
   endtask

   task automatic expect_out(input string name, input logic v, input logic [15:0] d,
                             input logic [3:0] bl, input logic [3:0] bd, input logic ov);
      checks++;
      if ({frame_valid, digits, blank, bad, overrun} !== {v, d, bl, bd, ov}) begin
         errors++;
         $display("FAIL %s got v=%b d=%h bl=%b bd=%b ov=%b want v=%b d=%h bl=%b bd=%b ov=%b",
                  name, frame_valid, digits, blank, bad, overrun, v, d, bl, bd, ov);
      end
   endtask

   typedef struct {
      logic [6:0] pat;
      logic [3:0] code;
      logic       bl;
      logic       bd;
   } vec_t;

   vec_t tbl[$];

   initial begin
      for (int k = 0; k < 10; k++) tbl.push_back('{GLYPH[k], 4'(k), 1'b0, 1'b0});
      tbl.push_back('{7'b0000001, 4'hF, 1'b0, 1'b0});
      tbl.push_back('{7'b0000000, 4'hA, 1'b1, 1'b0});
      tbl.push_back('{7'b1010101, 4'hE, 1'b0, 1'b1});
      tbl.push_back('{7'b0000011, 4'hE, 1'b0, 1'b1});

      model_reset();
      step(7'b0, 4'b0, 1'b0, 1'b0);
      step(7'b0, 4'b0, 1'b0, 1'b0);
      expect_out("reset_state", 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

      // Basic frame
      scan_digit(7'b1111110, 0, 4, 1'b1);
      scan_digit(7'b0110000, 1, 4, 1'b1);
      scan_digit(7'b1101101, 2, 4, 1'b1);
      scan_digit(7'b1111001, 3, 4, 1'b1);
      expect_out("no_frame_before_latency", 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      idle(1'b1);
      expect_out("frame_3210", 1'b1, 16'h3210, 4'h0, 4'h0, 1'b0);
      idle(1'b1);
      expect_out("frame_accept", 1'b0, 16'h3210, 4'h0, 4'h0, 1'b0);

      // Digit 2 too short to commit
      scan_digit(7'b1111110, 0, 4, 1'b1);
      scan_digit(7'b0110000, 1, 4, 1'b1);
      scan_digit(7'b1101101, 2, 2, 1'b1);
      scan_digit(7'b1111001, 3, 4, 1'b1);
      idle(1'b1);
      idle(1'b1);
      expect_out("short_hold_no_frame", 1'b0, 16'h3210, 4'h0, 4'h0, 1'b0);
      scan_digit(7'b1111110, 0, 4, 1'b0);
      scan_digit(7'b0110000, 1, 4, 1'b0);
      scan_digit(7'b0110011, 2, 4, 1'b0);
      idle(1'b0);
      expect_out("short_hold_recovered", 1'b1, 16'h3410, 4'h0, 4'h0, 1'b0);
      idle(1'b1);
      expect_out("short_hold_accept", 1'b0, 16'h3410, 4'h0, 4'h0, 1'b0);

      // Blank, dash and bad patterns
      scan_digit(7'b1010101, 0, 4, 1'b0);
      scan_digit(7'b0110000, 1, 4, 1'b0);
      scan_digit(7'b0000000, 2, 4, 1'b0);
      scan_digit(7'b0000001, 3, 4, 1'b0);
      idle(1'b0);
      expect_out("blank_dash_bad", 1'b1, 16'hFA1E, 4'b0100, 4'b0001, 1'b0);
      idle(1'b1);

      // Overrun
      scan_digit(GLYPH[5], 0, 4, 1'b0);
      scan_digit(GLYPH[6], 1, 4, 1'b0);
      scan_digit(GLYPH[7], 2, 4, 1'b0);
      scan_digit(GLYPH[8], 3, 4, 1'b0);
      idle(1'b0);
      expect_out("first_unaccepted", 1'b1, 16'h8765, 4'h0, 4'h0, 1'b0);
      scan_digit(GLYPH[9], 0, 4, 1'b0);
      scan_digit(GLYPH[0], 1, 4, 1'b0);
      expect_out("hold_while_not_ready", 1'b1, 16'h8765, 4'h0, 4'h0, 1'b0);
      scan_digit(GLYPH[2], 2, 4, 1'b0);
      scan_digit(GLYPH[3], 3, 4, 1'b0);
      idle(1'b0);
      expect_out("overrun_set", 1'b1, 16'h3209, 4'h0, 4'h0, 1'b1);
      idle(1'b1);
      expect_out("overrun_cleared", 1'b0, 16'h3209, 4'h0, 4'h0, 1'b0);

      // Reset mid-frame discards partial progress
      scan_digit(GLYPH[1], 0, 4, 1'b1);
      scan_digit(GLYPH[2], 1, 4, 1'b1);
      scan_digit(GLYPH[3], 2, 4, 1'b1);
      step(7'b0, 4'b0, 1'b1, 1'b0);
      expect_out("mid_reset_zero", 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      scan_digit(GLYPH[4], 3, 4, 1'b1);
      idle(1'b1);
      idle(1'b1);
      expect_out("partial_after_reset", 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      step(7'b0, 4'b0, 1'b0, 1'b0);

      // Decode table, every digit carrying the same glyph, minimum hold
      for (int t = 0; t < tbl.size(); t++) begin
         for (int d = 0; d < N; d++) scan_digit(tbl[t].pat, d, S, 1'b0);
         idle(1'b0);
         idle(1'b0);
         expect_out($sformatf("table_%0d", t), 1'b1, {4{tbl[t].code}},
                    {4{tbl[t].bl}}, {4{tbl[t].bd}}, 1'b0);
         idle(1'b1);
      end

      // Randomized scans against the reference model
      for (int n = 0; n < 600; n++) begin
         logic [3:0] sel;
         logic [6:0] pat;
         int         hold;
         sel  = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
         pat  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : GLYPH[$urandom_range(0, 10)];
         hold = $urandom_range(1, 5);
         for (int h = 0; h < hold; h++) begin
            step(pat, sel, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) != 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
